// File: rtl/rr_mux_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rr_mux_arbiter_pkg
//  Brief    : Shared types and constants for the round-robin mux arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package rr_mux_arbiter_pkg;

    // Number of requesters sharing the mux and the width of an index into them
    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    // Arbiter FSM encoding
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage : rr_mux_arbiter_pkg
`default_nettype wire

// File: rtl/rr_mux_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : rr_mux_arbiter_if
//  Brief    : Requester-side bus of the round-robin mux arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
interface rr_mux_arbiter_if
    import rr_mux_arbiter_pkg::*;
();

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] data_in;
    logic [N_REQ-1:0] gnt;
    logic [SEL_W-1:0] sel;
    logic             valid;
    logic             data_out;

    // Requester logic drives requests and data, observes the grant
    modport master (
        output req,
        output data_in,
        input  gnt,
        input  sel,
        input  valid,
        input  data_out
    );

    // Arbiter side
    modport slave (
        input  req,
        input  data_in,
        output gnt,
        output sel,
        output valid,
        output data_out
    );

endinterface : rr_mux_arbiter_if
`default_nettype wire

// File: rtl/decoder_3input.sv
`default_nettype none
// ============================================================================
//  Module   : decoder_3input
//  Brief    : 3-to-8 one-hot decoder; s0 is the select MSB.
//  Revision : 1.0 - initial release
// ============================================================================
module decoder_3input (
    input  wire logic       s0,
    input  wire logic       s1,
    input  wire logic       s2,
    output logic [7:0]      y
);

    assign y = 8'b0000_0001 << {s0, s1, s2};

endmodule : decoder_3input
`default_nettype wire

// File: rtl/multiplexer_8input.sv
`default_nettype none
// ============================================================================
//  Module   : multiplexer_8input
//  Brief    : 8-input, 1-bit multiplexer; s0 is the select LSB.
//  Revision : 1.0 - initial release
// ============================================================================
module multiplexer_8input (
    input  wire logic [7:0] d,
    input  wire logic       s0,
    input  wire logic       s1,
    input  wire logic       s2,
    output logic            y
);

    assign y = d[{s2, s1, s0}];

endmodule : multiplexer_8input
`default_nettype wire

// File: rtl/rr_mux_arbiter_pick8.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick8
//  Brief    : Rotating-priority finder; returns the first set request
//             searching last+1, last+2, ... modulo 8.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_pick8
    import rr_mux_arbiter_pkg::*;
(
    input  wire logic [N_REQ-1:0] req,
    input  wire logic [SEL_W-1:0] last,
    output logic      [SEL_W-1:0] idx,
    output logic                  any
);

    logic [SEL_W-1:0] w_pos;

    // Scan from farthest (last itself) to nearest (last+1) so the nearest hit wins
    always_comb begin
        idx   = '0;
        any   = 1'b0;
        w_pos = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_pos = last + SEL_W'(k);
            if (req[w_pos]) begin
                idx = w_pos;
                any = 1'b1;
            end
        end
    end

endmodule : rr_pick8
`default_nettype wire

// File: rtl/rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_mux_arbiter
//  Brief    : Round-robin arbiter sharing an 8-input 1-bit mux between 8
//             requesters, with bounded grant length and a one-cycle gap.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 4
) (
    input  wire logic          clk,
    input  wire logic          reset,
    rr_mux_arbiter_if.slave    bus
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] w_sel_nxt;
    logic [SEL_W-1:0] r_last;
    logic [SEL_W-1:0] w_last_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [N_REQ-1:0] r_gnt;
    logic [N_REQ-1:0] w_gnt_nxt;
    logic [N_REQ-1:0] w_dec;
    logic             r_valid;
    logic             w_valid_nxt;
    logic             w_any;
    logic [SEL_W-1:0] w_idx;
    logic             w_mux;

    rr_pick8 u_pick (
        .req  (bus.req),
        .last (r_last),
        .idx  (w_idx),
        .any  (w_any)
    );

    // Decoder select s0 is the MSB, so the index bits go in reversed order
    decoder_3input u_dec (
        .s0 (w_sel_nxt[2]),
        .s1 (w_sel_nxt[1]),
        .s2 (w_sel_nxt[0]),
        .y  (w_dec)
    );

    // Mux select s0 is the LSB
    multiplexer_8input u_mux (
        .d  (bus.data_in),
        .s0 (r_sel[0]),
        .s1 (r_sel[1]),
        .s2 (r_sel[2]),
        .y  (w_mux)
    );

    // Next-state and next-output decisions for the IDLE/GRANT controller
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        w_valid_nxt = r_valid;
        case (r_state)
            IDLE: begin
                w_valid_nxt = 1'b0;
                if (w_any) begin
                    w_state_nxt = GRANT;
                    w_sel_nxt   = w_idx;
                    w_valid_nxt = 1'b1;
                    w_cnt_nxt   = '0;
                end
            end
            GRANT: begin
                // Release on dropped request or on the last allowed cycle
                if (!bus.req[r_sel] || (r_cnt == CNT_W'(MAX_HOLD - 1))) begin
                    w_state_nxt = IDLE;
                    w_valid_nxt = 1'b0;
                    w_last_nxt  = r_sel;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
        w_gnt_nxt = w_valid_nxt ? w_dec : '0;
    end

    // State and registered outputs; reset forgets any grant in progress
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_last  <= SEL_W'(N_REQ - 1);
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gnt   <= w_gnt_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    assign bus.gnt      = r_gnt;
    assign bus.sel      = r_sel;
    assign bus.valid    = r_valid;
    assign bus.data_out = w_mux & r_valid;

endmodule : rr_mux_arbiter
`default_nettype wire

// File: tb/tb_rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_mux_arbiter
//  Brief    : Directed self-checking bench for rr_mux_arbiter (MAX_HOLD=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rr_mux_arbiter;

    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;

    rr_mux_arbiter_if bus ();

    rr_mux_arbiter #(
        .MAX_HOLD (4),
        .CNT_W    (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_grant(input string tag, input logic [7:0] g, input logic [2:0] s, input logic v);
        chk({tag, ".gnt"},   bus.gnt,          g);
        chk({tag, ".sel"},   {5'd0, bus.sel},  {5'd0, s});
        chk({tag, ".valid"}, {7'd0, bus.valid}, {7'd0, v});
    endtask

    initial begin
        n_assert    = 0;
        n_fail      = 0;
        reset       = 1'b1;
        bus.req     = 8'hFF;
        bus.data_in = 8'h00;

        // Reset held two cycles with all requests active
        tick();
        tick();
        chk_grant("reset", 8'h00, 3'd0, 1'b0);
        bus.data_in = 8'hFF;
        #1;
        chk("reset.data_out", {7'd0, bus.data_out}, 8'h00);
        bus.data_in = 8'h00;
        reset       = 1'b0;

        // Full contention: 0..7 then 0 again, 4 cycles each plus a 1-cycle gap
        for (int g = 0; g < 9; g++) begin
            for (int c = 0; c < 4; c++) begin
                tick();
                chk_grant($sformatf("contend%0d_c%0d", g, c),
                          8'h01 << (g % 8), 3'(g % 8), 1'b1);
            end
            tick();
            chk_grant($sformatf("contend%0d_gap", g), 8'h00, 3'(g % 8), 1'b0);
        end

        // Steady lone requester 3: two rounds of 4 granted cycles and a gap
        bus.req = 8'h08;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 4; c++) begin
                tick();
                chk_grant($sformatf("single_r%0d_c%0d", r, c), 8'h08, 3'd3, 1'b1);
            end
            tick();
            chk_grant($sformatf("single_r%0d_gap", r), 8'h00, 3'd3, 1'b0);
        end

        // Grant requester 6 and check data routing
        bus.req = 8'h40;
        tick();
        chk_grant("route", 8'h40, 3'd6, 1'b1);
        bus.data_in = 8'h40;
        #1;
        chk("route.data_hi", {7'd0, bus.data_out}, 8'h01);
        bus.data_in = 8'hBF;
        #1;
        chk("route.data_lo", {7'd0, bus.data_out}, 8'h00);

        // Drop request 6 immediately: released, pointer now 6
        bus.req = 8'h00;
        tick();
        chk_grant("drop6", 8'h00, 3'd6, 1'b0);
        bus.data_in = 8'hFF;
        #1;
        chk("idle.data_out", {7'd0, bus.data_out}, 8'h00);
        bus.data_in = 8'h00;

        // Early drop with wrap: last=6, req 0 and 5 -> 0 wins
        bus.req = 8'h21;
        tick();
        chk_grant("wrap_c0", 8'h01, 3'd0, 1'b1);
        tick();
        chk_grant("wrap_c1", 8'h01, 3'd0, 1'b1);
        tick();
        chk_grant("wrap_c2", 8'h01, 3'd0, 1'b1);
        bus.req = 8'h20;
        tick();
        chk_grant("wrap_gap", 8'h00, 3'd0, 1'b0);
        tick();
        chk_grant("wrap_next", 8'h20, 3'd5, 1'b1);

        // Reset in the middle of a grant to requester 2 (hold count 2)
        bus.req = 8'h04;
        tick();
        chk_grant("pre_rst_gap", 8'h00, 3'd5, 1'b0);
        tick();
        chk_grant("pre_rst_c0", 8'h04, 3'd2, 1'b1);
        tick();
        tick();
        chk_grant("pre_rst_c2", 8'h04, 3'd2, 1'b1);
        reset   = 1'b1;
        bus.req = 8'h84;
        tick();
        chk_grant("mid_rst", 8'h00, 3'd0, 1'b0);
        reset = 1'b0;
        tick();
        chk_grant("post_rst", 8'h04, 3'd2, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_rr_mux_arbiter
`default_nettype wire
